// File: rtl/seq_booth_multiplier_pkg.sv
// Shared definitions for multi-cycle arithmetic blocks: FSM state encoding
// and iteration-counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of a down-counter that must hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/seq_booth_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the upper half,
// followed by an arithmetic right shift of {acc, Q, q_m1}.
module booth_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] q_i,
    input  logic         q_m1_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] q_o,
    output logic         q_m1_o
);

    logic [W-1:0] sum;

    // Booth recoding of {q0, q(-1)} selects add, subtract or pass-through.
    always_comb begin
        sum = acc_i;
        case ({q_i[0], q_m1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    assign acc_o  = {sum[W-1], sum[W-1:1]};
    assign q_o    = {sum[0], q_i[W-1:1]};
    assign q_m1_o = q_i[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier with start/done handshake and runtime
// signed/unsigned mode; one result every N+2 cycles.
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    // One extra bit lets both unsigned and signed operands be handled as signed.
    localparam int W  = N + 1;
    localparam int CW = cnt_width(N + 1);

    mult_state_t    state_q;
    logic [W-1:0]   m_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   q_q;
    logic           qm1_q;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   q_d;
    logic           qm1_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [2*N-1:0] product_q;

    booth_step #(.W(W)) u_step (
        .acc_i  (acc_q),
        .q_i    (q_q),
        .q_m1_i (qm1_q),
        .m_i    (m_q),
        .acc_o  (acc_d),
        .q_o    (q_d),
        .q_m1_o (qm1_d)
    );

    // Control FSM, iteration counter, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= {signed_mode & a[N-1], a};
                        q_q     <= {signed_mode & b[N-1], b};
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CW'(N + 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The top two bits of {acc, Q} are pure sign extension.
                    product_q <= {acc_q[N-2:0], q_q};
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Randomized and directed bench for seq_booth_multiplier at N=5, N=4 and N=16
// against a plain-arithmetic product model.
module tb_seq_booth_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start5 = 1'b0, sm5 = 1'b0;
    logic [4:0]  a5 = 5'd0, b5 = 5'd0;
    logic [9:0]  p5;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = 4'd0, b4 = 4'd0;
    logic [7:0]  p4;
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic [31:0] p16;

    logic        busy_w [3];
    logic        done_w [3];
    logic [63:0] prod_w [3];
    int          nw [3] = '{5, 4, 16};

    int vectors = 0;
    int miscompares = 0;

    assign prod_w[0] = {54'd0, p5};
    assign prod_w[1] = {56'd0, p4};
    assign prod_w[2] = {32'd0, p16};

    seq_booth_multiplier #(.N(5)) u_n5 (
        .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5), .a(a5), .b(b5),
        .busy(busy_w[0]), .done(done_w[0]), .product(p5)
    );
    seq_booth_multiplier #(.N(4)) u_n4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy_w[1]), .done(done_w[1]), .product(p4)
    );
    seq_booth_multiplier #(.N(16)) u_n16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy_w[2]), .done(done_w[2]), .product(p16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands per mode, multiply as integers, keep 2N bits.
    function automatic logic [63:0] ref_mul(input int n, input logic [15:0] av,
                                            input logic [15:0] bv, input logic sm);
        longint lim, sa, sb;
        lim = longint'(1) << n;
        sa  = longint'(av) & (lim - 1);
        sb  = longint'(bv) & (lim - 1);
        if (sm && sa >= lim / 2) sa = sa - lim;
        if (sm && sb >= lim / 2) sb = sb - lim;
        return 64'(sa * sb) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    task automatic drive(input int s, input logic st, input logic [15:0] av,
                         input logic [15:0] bv, input logic sm);
        case (s)
            0: begin start5 = st; a5 = av[4:0]; b5 = bv[4:0]; sm5 = sm; end
            1: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; sm4 = sm; end
            default: begin start16 = st; a16 = av; b16 = bv; sm16 = sm; end
        endcase
    endtask

    // lat = index of the sampled cycle (1 = cycle after acceptance) with done high; 0 if none.
    task automatic wait_done(input int s, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_w[s]) begin
                lat = i;
                break;
            end
            if (busy_w[s]) busy_cnt++;
        end
    endtask

    task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input bit hold);
        int n, lat, bc;
        logic [63:0] exp;
        n = nw[s];
        @(negedge clk);
        drive(s, 1'b1, av, bv, sm);
        exp = ref_mul(n, av, bv, sm);
        @(posedge clk);
        #1;
        if (hold) drive(s, 1'b1, ~av, bv + 16'd1, sm);
        else      drive(s, 1'b0, av, bv, sm);
        wait_done(s, lat, bc);
        check("latency", 64'(lat - 1), 64'(n + 2));
        check("busy_len", 64'(bc), 64'(n + 2));
        check("product", prod_w[s], exp);
        @(negedge clk);
        check("done_pulse", {63'd0, done_w[s]}, 64'd0);
        if (hold) begin
            check("restart_busy", {63'd0, busy_w[s]}, 64'd1);
            exp = ref_mul(n, ~av, bv + 16'd1, sm);
            drive(s, 1'b0, ~av, bv + 16'd1, sm);
            wait_done(s, lat, bc);
            check("held_lat_seen", {63'd0, lat != 0}, 64'd1);
            check("held_product", prod_w[s], exp);
        end else begin
            check("idle_busy", {63'd0, busy_w[s]}, 64'd0);
        end
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("rst_busy", {63'd0, busy_w[s]}, 64'd0);
            check("rst_done", {63'd0, done_w[s]}, 64'd0);
            check("rst_product", prod_w[s], 64'd0);
        end

        do_op(0, 16'd5,  16'd3,  1'b1, 1'b0);
        do_op(0, 16'd29, 16'd3,  1'b1, 1'b0);
        do_op(0, 16'd29, 16'd30, 1'b1, 1'b0);
        do_op(0, 16'd16, 16'd16, 1'b1, 1'b0);
        do_op(0, 16'd29, 16'd3,  1'b0, 1'b0);
        do_op(0, 16'd31, 16'd31, 1'b0, 1'b0);
        do_op(0, 16'd5,  16'd3,  1'b1, 1'b1);

        // Abort two cycles into CALC, with a start in the reset cycle.
        @(negedge clk);
        drive(0, 1'b1, 16'd13, 16'd7, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 16'd13, 16'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 16'd10, 16'd5, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 16'd10, 16'd5, 1'b1);
        check("abort_busy", {63'd0, busy_w[0]}, 64'd0);
        check("abort_done", {63'd0, done_w[0]}, 64'd0);
        check("abort_product", prod_w[0], 64'd0);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) dn++;
        end
        check("abort_quiet", 64'(dn), 64'd0);
        do_op(0, 16'd10, 16'd5, 1'b1, 1'b0);

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    do_op(1, 16'(x), 16'(y), m[0], 1'b0);

        do_op(2, 16'h8000, 16'h8000, 1'b1, 1'b0);
        do_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 150; k++)
            do_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
